// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// One owner at a time: grant, WAIT_CYCLES of port activity, then a one-cycle ready pulse.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int                CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic w_grant;
    logic w_grant_dm;
    logic w_done;

    // On a tie the requester that did not win last time gets the port.
    assign w_grant    = (r_state == S_IDLE) && (if_req || dm_req);
    assign w_grant_dm = dm_req && (!if_req || (r_last_grant == OWN_IF));
    assign w_done     = (r_state == S_ACCESS) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_IF;
            r_last_grant <= OWN_IF;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state      <= S_ACCESS;
                        r_cnt        <= '0;
                        r_owner      <= w_grant_dm ? OWN_DM : OWN_IF;
                        r_last_grant <= w_grant_dm ? OWN_DM : OWN_IF;
                        r_addr       <= w_grant_dm ? dm_addr : if_addr;
                        r_we         <= w_grant_dm ? dm_we : 1'b0;
                        r_wdata      <= dm_wdata;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (w_done) begin
                        r_state <= S_RESP;
                        if (!r_we) begin
                            if (r_owner == OWN_DM) r_dm_rdata <= mem_rdata;
                            else                   r_if_rdata <= mem_rdata;
                        end
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_en    = (r_state == S_ACCESS);
    assign mem_we    = mem_en && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign if_ready  = (r_state == S_RESP) && (r_owner == OWN_IF);
    assign dm_ready  = (r_state == S_RESP) && (r_owner == OWN_DM);
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

    // Stalls release in the ready cycle so the stage advances on the next edge.
    assign stall_if  = if_req && !if_ready;
    assign stall_mem = dm_req && !dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at WAIT_CYCLES=2, one at WAIT_CYCLES=1.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_en, mem_we, stall_if, stall_mem;

    logic        b_if_req = 1'b0;
    logic [31:0] b_if_addr = '0;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_if_ready, b_dm_ready, b_mem_en, b_mem_we, b_stall_if, b_stall_mem;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000AAAA;
            32'h4:   return 32'h20080005;
            32'h8:   return 32'h8C220008;
            32'h20:  return 32'h11111111;
            32'h30:  return 32'hCAFE0030;
            default: return 32'hBAD0BAD0;
        endcase
    endfunction

    assign mem_rdata   = memf(mem_addr);
    assign b_mem_rdata = memf(b_mem_addr);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .stall_if(b_stall_if), .stall_mem(b_stall_mem)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        if_req = 1'b1;
        #7;
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_en got en=%b we=%b exp 0 0", mem_en, mem_we); end
        checks++; if (if_ready !== 1'b0 || dm_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b%b exp 00", if_ready, dm_ready); end
        checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_regs got %h %h %h %h exp zeros", if_rdata, dm_rdata, mem_addr, mem_wdata); end
        checks++; if (stall_if !== 1'b1 || stall_mem !== 1'b0) begin failures++; $display("FAIL reset_stall got %b%b exp 10", stall_if, stall_mem); end
        if_req = 1'b0;
        @(negedge clk) reset = 1'b1;
    endtask

    task automatic test_if_read;
        if_addr = 32'h4; if_req = 1'b1;
        #1;
        checks++; if (stall_if !== 1'b1) begin failures++; $display("FAIL ifrd_stall0 got %b exp 1", stall_if); end
        tick;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h4) begin failures++; $display("FAIL ifrd_c1 got en=%b we=%b a=%h exp 1 0 4", mem_en, mem_we, mem_addr); end
        checks++; if (if_ready !== 1'b0 || stall_if !== 1'b1) begin failures++; $display("FAIL ifrd_c1_rdy got rdy=%b st=%b exp 0 1", if_ready, stall_if); end
        tick;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h4 || if_ready !== 1'b0 || stall_if !== 1'b1) begin failures++; $display("FAIL ifrd_c2 got en=%b a=%h rdy=%b st=%b exp 1 4 0 1", mem_en, mem_addr, if_ready, stall_if); end
        tick;
        checks++; if (mem_en !== 1'b0 || if_ready !== 1'b1 || stall_if !== 1'b0) begin failures++; $display("FAIL ifrd_c3 got en=%b rdy=%b st=%b exp 0 1 0", mem_en, if_ready, stall_if); end
        checks++; if (if_rdata !== 32'h20080005) begin failures++; $display("FAIL ifrd_data got %h exp 20080005", if_rdata); end
        if_req = 1'b0;
        tick;
        checks++; if (if_ready !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL ifrd_c4 got rdy=%b en=%b exp 0 0", if_ready, mem_en); end
    endtask

    task automatic test_dm_write;
        dm_addr = 32'h10; dm_wdata = 32'hDEADBEEF; dm_we = 1'b1; dm_req = 1'b1;
        tick;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL dmwr_c1 got en=%b we=%b a=%h d=%h", mem_en, mem_we, mem_addr, mem_wdata); end
        tick;
        checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || dm_ready !== 1'b0) begin failures++; $display("FAIL dmwr_c2 got we=%b d=%h rdy=%b", mem_we, mem_wdata, dm_ready); end
        tick;
        checks++; if (dm_ready !== 1'b1 || mem_we !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("FAIL dmwr_c3 got rdy=%b we=%b en=%b exp 1 0 0", dm_ready, mem_we, mem_en); end
        checks++; if (dm_rdata !== 32'h0 || if_rdata !== 32'h20080005) begin failures++; $display("FAIL dmwr_rdata got dm=%h if=%h exp 0 20080005", dm_rdata, if_rdata); end
        checks++; if (mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h10) begin failures++; $display("FAIL dmwr_hold got a=%h d=%h", mem_addr, mem_wdata); end
        dm_req = 1'b0; dm_we = 1'b0;
        tick;
        checks++; if (dm_ready !== 1'b0) begin failures++; $display("FAIL dmwr_c4 got rdy=%b exp 0", dm_ready); end
    endtask

    task automatic test_tie;
        logic [31:0] g_addr [4];
        int          g_cyc [4];
        int          ng = 0;
        logic        prev_en = 1'b0;
        logic [31:0] exp_a [4];
        exp_a[0] = 32'h20; exp_a[1] = 32'h8; exp_a[2] = 32'h20; exp_a[3] = 32'h8;
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        dm_addr = 32'h20; dm_we = 1'b0; if_addr = 32'h8;
        dm_req = 1'b1; if_req = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick;
            if (mem_en && !prev_en && ng < 4) begin g_addr[ng] = mem_addr; g_cyc[ng] = c; ng++; end
            prev_en = mem_en;
            if (c == 2) begin
                checks++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h11111111) begin failures++; $display("FAIL tie_dmdata got rdy=%b d=%h exp 1 11111111", dm_ready, dm_rdata); end
            end
        end
        dm_req = 1'b0; if_req = 1'b0;
        checks++; if (ng !== 4) begin failures++; $display("FAIL tie_count got %0d exp 4", ng); end
        for (int i = 0; i < ng; i++) begin
            checks++; if (g_addr[i] !== exp_a[i] || g_cyc[i] !== 4 * i) begin failures++; $display("FAIL tie_grant%0d got a=%h c=%0d exp a=%h c=%0d", i, g_addr[i], g_cyc[i], exp_a[i], 4 * i); end
        end
        tick;
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL tie_idle got en=%b exp 0", mem_en); end
    endtask

    task automatic test_reset_mid;
        if_addr = 32'h4; if_req = 1'b1;
        tick;
        checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL rmid_start got en=%b exp 1", mem_en); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0 || if_ready !== 1'b0 || stall_if !== 1'b1 || if_rdata !== 32'h0) begin failures++; $display("FAIL rmid_abort got en=%b rdy=%b st=%b d=%h", mem_en, if_ready, stall_if, if_rdata); end
        tick;
        checks++; if (mem_en !== 1'b0 || if_ready !== 1'b0) begin failures++; $display("FAIL rmid_held got en=%b rdy=%b exp 0 0", mem_en, if_ready); end
        @(negedge clk) reset = 1'b1;
        tick;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h4 || if_ready !== 1'b0) begin failures++; $display("FAIL rmid_c1 got en=%b a=%h rdy=%b", mem_en, mem_addr, if_ready); end
        tick;
        checks++; if (mem_en !== 1'b1 || if_ready !== 1'b0) begin failures++; $display("FAIL rmid_c2 got en=%b rdy=%b exp 1 0", mem_en, if_ready); end
        tick;
        checks++; if (mem_en !== 1'b0 || if_ready !== 1'b1 || if_rdata !== 32'h20080005) begin failures++; $display("FAIL rmid_c3 got en=%b rdy=%b d=%h", mem_en, if_ready, if_rdata); end
        if_req = 1'b0;
        tick;
    endtask

    task automatic test_withdraw;
        dm_addr = 32'h30; dm_we = 1'b0; dm_req = 1'b1;
        tick;
        tick;
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h30) begin failures++; $display("FAIL wd_c2 got en=%b a=%h exp 1 30", mem_en, mem_addr); end
        dm_req = 1'b0;
        #1;
        checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL wd_stall got %b exp 0", stall_mem); end
        tick;
        checks++; if (dm_ready !== 1'b1 || dm_rdata !== 32'hCAFE0030) begin failures++; $display("FAIL wd_ready got rdy=%b d=%h exp 1 cafe0030", dm_ready, dm_rdata); end
        tick;
        checks++; if (mem_en !== 1'b0 || dm_ready !== 1'b0) begin failures++; $display("FAIL wd_idle got en=%b rdy=%b exp 0 0", mem_en, dm_ready); end
        tick;
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL wd_nogrant got en=%b exp 0", mem_en); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        int          k = 0;
        logic        exp_en, exp_rdy;
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        datas[0] = 32'h0000AAAA; datas[1] = 32'h20080005; datas[2] = 32'h8C220008;
        b_if_addr = addrs[0]; b_if_req = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick;
            exp_en  = (c % 3 == 0) && (c < 9);
            exp_rdy = (c % 3 == 1);
            checks++; if (b_mem_en !== exp_en) begin failures++; $display("FAIL w1_en c=%0d got %b exp %b", c, b_mem_en, exp_en); end
            checks++; if (b_if_ready !== exp_rdy) begin failures++; $display("FAIL w1_rdy c=%0d got %b exp %b", c, b_if_ready, exp_rdy); end
            if (exp_rdy && k < 3) begin
                checks++; if (b_if_rdata !== datas[k]) begin failures++; $display("FAIL w1_data%0d got %h exp %h", k, b_if_rdata, datas[k]); end
                k++;
                if (k < 3) b_if_addr = addrs[k];
                else       b_if_req = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset;
        test_if_read;
        test_dm_write;
        test_tie;
        test_reset_mid;
        test_withdraw;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
